// File: rtl/sha256_chunk_feeder.sv
// rtl/sha256_chunk_feeder.sv - SHA-256 message packer/padder and digest chainer around a compression pipeline
//
// Purpose:
//   Packs a big-endian 32-bit word stream into 512-bit chunks and appends the SHA-256
//   padding (0x80, zeros, 64-bit bit length). Each chunk is issued to the external
//   64-stage compression pipeline together with the chaining value H. The pipeline
//   result is folded into H (ori + final per lane). After the final chunk the
//   256-bit digest is presented until the consumer accepts it.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   s_valid/s_ready     message word handshake (s_ready only in FILL)
//   s_data/s_last       message word (first byte in [31:24]), last-word marker
//   s_bytes             valid bytes of the last word, 0 means 4
//   c_validin           one-cycle chunk strobe to the pipeline
//   c_chunk/c_init      chunk (word j at [32*j+:32]) and chaining value (lane a at [31:0])
//   c_validout          pipeline result strobe
//   c_final/c_ori       pipeline final a..h and delayed init a..h (lane a at [31:0])
//   d_valid/d_ready     digest handshake
//   d_digest            H0 at [255:224] .. H7 at [31:0]
//   busy                not idle
//   err                 sticky watchdog error
//
// Optional macro: SHA256_FEEDER_WDOG_EN enables a 128-cycle watchdog on the pipeline
//   result; without it WAIT waits indefinitely and err is tied low.
module sha256_chunk_feeder #(
   parameter int CHUNKSIZE = 512,
   parameter int LENCNT_W  = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [31:0]          s_data,
   input  logic                 s_last,
   input  logic [1:0]           s_bytes,
   output logic                 c_validin,
   output logic [CHUNKSIZE-1:0] c_chunk,
   output logic [255:0]         c_init,
   input  logic                 c_validout,
   input  logic [255:0]         c_final,
   input  logic [255:0]         c_ori,
   output logic                 d_valid,
   input  logic                 d_ready,
   output logic [255:0]         d_digest,
   output logic                 busy,
   output logic                 err
);

   // SHA-256 initial hash value, lane a (H0) in the low word
   localparam logic [255:0] IV_LANES =
      256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;
   localparam int LEN_PAD = 61 - LENCNT_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_PAD,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [15:0][31:0]      r_buf;
   logic [3:0]             r_idx;
   logic [LENCNT_W-1:0]    r_bytes;
   logic [CHUNKSIZE-1:0]   r_chunk;
   logic [255:0]           r_init;
   logic [255:0]           r_h;
   logic                   r_fin;
   logic                   r_padonly;
   logic                   r_pad80;

   logic [2:0]             w_nbytes;
   logic [LENCNT_W-1:0]    w_bytes_next;
   logic [63:0]            w_len64;
   logic [63:0]            w_pad_len64;
   logic [31:0]            w_word;
   logic                   w_last_full;
   logic                   w_fits;
   logic                   w_pad80;
   logic [CHUNKSIZE-1:0]   w_chunk;
   logic [CHUNKSIZE-1:0]   w_pad_chunk;
   logic                   w_wdog_expire;

   assign c_chunk = r_chunk;
   assign c_init  = r_init;

   assign w_nbytes     = (s_last && s_bytes != 2'd0) ? {1'b0, s_bytes} : 3'd4;
   assign w_bytes_next = r_bytes + LENCNT_W'(w_nbytes);
   assign w_len64      = {{LEN_PAD{1'b0}}, w_bytes_next, 3'b000};
   assign w_pad_len64  = {{LEN_PAD{1'b0}}, r_bytes, 3'b000};
   assign w_last_full  = s_last && (s_bytes == 2'd0);
   // The length fits in this chunk only if the 0x80 marker lands at word 13 or earlier
   assign w_fits       = s_last && (w_last_full ? (r_idx <= 4'd12) : (r_idx <= 4'd13));
   // A full last word at index 15 pushes the 0x80 marker into the pad-only chunk
   assign w_pad80      = w_last_full && (r_idx == 4'd15);

   // Last word: keep the valid bytes and drop the 0x80 marker right behind them
   always_comb begin
      w_word = s_data;
      if (s_last) begin
         case (s_bytes)
            2'd1:    w_word = {s_data[31:24], 8'h80, 16'h0000};
            2'd2:    w_word = {s_data[31:16], 8'h80, 8'h00};
            2'd3:    w_word = {s_data[31:8], 8'h80};
            default: w_word = s_data;
         endcase
      end
   end

   // Chunk as it will be issued when the current word is accepted
   always_comb begin
      w_chunk = '0;
      for (int j = 0; j < 16; j++) begin
         if (j < int'(r_idx)) begin
            w_chunk[32*j +: 32] = r_buf[j];
         end else if (j == int'(r_idx)) begin
            w_chunk[32*j +: 32] = w_word;
         end else if ((j == int'(r_idx) + 1) && w_last_full) begin
            w_chunk[32*j +: 32] = 32'h8000_0000;
         end
      end
      if (w_fits) begin
         w_chunk[32*14 +: 32] = w_len64[63:32];
         w_chunk[32*15 +: 32] = w_len64[31:0];
      end
   end

   always_comb begin
      w_pad_chunk          = '0;
      w_pad_chunk[31:0]    = r_pad80 ? 32'h8000_0000 : 32'h0000_0000;
      w_pad_chunk[32*14 +: 32] = w_pad_len64[63:32];
      w_pad_chunk[32*15 +: 32] = w_pad_len64[31:0];
   end

   // Digest is only driven while presented so it reads zero elsewhere
   always_comb begin
      d_digest = '0;
      if (r_state == ST_DONE) begin
         for (int i = 0; i < 8; i++) begin
            d_digest[32*(7-i) +: 32] = r_h[32*i +: 32];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      s_ready   = 1'b0;
      c_validin = 1'b0;
      d_valid   = 1'b0;
      busy      = 1'b1;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (s_valid) w_next = ST_FILL;
         end
         ST_FILL: begin
            s_ready = 1'b1;
            if (s_valid && (s_last || r_idx == 4'd15)) w_next = ST_ISSUE;
         end
         ST_PAD: begin
            w_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            c_validin = 1'b1;
            w_next    = ST_WAIT;
         end
         ST_WAIT: begin
            if (c_validout) begin
               if (r_fin)          w_next = ST_DONE;
               else if (r_padonly) w_next = ST_PAD;
               else                w_next = ST_FILL;
            end else if (w_wdog_expire) begin
               w_next = ST_IDLE;
            end
         end
         ST_DONE: begin
            d_valid = 1'b1;
            if (d_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_buf     <= '0;
         r_idx     <= '0;
         r_bytes   <= '0;
         r_chunk   <= '0;
         r_init    <= '0;
         r_h       <= IV_LANES;
         r_fin     <= 1'b0;
         r_padonly <= 1'b0;
         r_pad80   <= 1'b0;
      end else begin
         case (r_state)
            ST_FILL: begin
               if (s_valid) begin
                  r_buf[r_idx] <= w_word;
                  r_bytes      <= w_bytes_next;
                  if (s_last || r_idx == 4'd15) begin
                     r_idx     <= '0;
                     r_chunk   <= w_chunk;
                     r_init    <= r_h;
                     r_fin     <= w_fits;
                     r_padonly <= s_last && !w_fits;
                     r_pad80   <= w_pad80;
                  end else begin
                     r_idx <= r_idx + 4'd1;
                  end
               end
            end
            ST_PAD: begin
               r_chunk   <= w_pad_chunk;
               r_init    <= r_h;
               r_fin     <= 1'b1;
               r_padonly <= 1'b0;
               r_pad80   <= 1'b0;
            end
            ST_WAIT: begin
               if (c_validout) begin
                  for (int i = 0; i < 8; i++) begin
                     r_h[32*i +: 32] <= c_ori[32*i +: 32] + c_final[32*i +: 32];
                  end
               end else if (w_wdog_expire) begin
                  r_h       <= IV_LANES;
                  r_bytes   <= '0;
                  r_idx     <= '0;
                  r_fin     <= 1'b0;
                  r_padonly <= 1'b0;
                  r_pad80   <= 1'b0;
               end
            end
            ST_DONE: begin
               if (d_ready) begin
                  r_h     <= IV_LANES;
                  r_bytes <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SHA256_FEEDER_WDOG_EN
   logic [7:0] r_wdog;
   logic       r_err;

   // Counter is cleared in ISSUE so it starts from zero on the first WAIT cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wdog <= '0;
         r_err  <= 1'b0;
      end else begin
         if (r_state == ST_ISSUE) begin
            r_wdog <= '0;
         end else if (r_state == ST_WAIT) begin
            r_wdog <= r_wdog + 8'd1;
         end
         if (w_wdog_expire) r_err <= 1'b1;
      end
   end

   assign w_wdog_expire = (r_state == ST_WAIT) && !c_validout && (r_wdog == 8'd127);
   assign err           = r_err;
`else
   assign w_wdog_expire = 1'b0;
   assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_chunk_feeder.sv
// tb/tb_sha256_chunk_feeder.sv - self-checking bench for sha256_chunk_feeder
`timescale 1ns/1ps
module tb_sha256_chunk_feeder;

   typedef logic [7:0] byte_q_t [$];

   typedef struct {
      string        txt;
      int           len;
      bit           has_dig;
      logic [255:0] dig;
      int           strobes;
      logic [31:0]  w0;
      logic [31:0]  w15;
      bit           mid_zero;
      int           hold;
   } vec_t;

   localparam logic [255:0] IV_LANES =
      256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [31:0]  s_data = '0;
   logic         s_last = 1'b0;
   logic [1:0]   s_bytes = '0;
   logic         c_validin;
   logic [511:0] c_chunk;
   logic [255:0] c_init;
   logic         c_validout = 1'b0;
   logic [255:0] c_final = '0;
   logic [255:0] c_ori = '0;
   logic         d_valid;
   logic         d_ready = 1'b0;
   logic [255:0] d_digest;
   logic         busy;
   logic         err;

   int           checks = 0;
   int           failures = 0;
   int           n_strobes = 0;
   logic [511:0] last_chunk = '0;
   bit           stub_en = 1'b1;

   vec_t         vecs [8];
   byte_q_t      msg;
   logic [255:0] exp_d;
   int           s0;
   int           t;
   int           len;
   bit           quiet;

   sha256_chunk_feeder dut (
      .clk        (clk),
      .reset      (reset),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .s_bytes    (s_bytes),
      .c_validin  (c_validin),
      .c_chunk    (c_chunk),
      .c_init     (c_init),
      .c_validout (c_validout),
      .c_final    (c_final),
      .c_ori      (c_ori),
      .d_valid    (d_valid),
      .d_ready    (d_ready),
      .d_digest   (d_digest),
      .busy       (busy),
      .err        (err)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // SHA-256 compression rounds only; returns final a..h (lane a low), no feed-forward add
   function automatic logic [255:0] compress(input logic [255:0] init, input logic [511:0] chunk);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      for (int j = 0; j < 16; j++) w[j] = chunk[32*j +: 32];
      for (int j = 16; j < 64; j++) begin
         w[j] = (rotr(w[j-2], 17) ^ rotr(w[j-2], 19) ^ (w[j-2] >> 10)) + w[j-7]
              + (rotr(w[j-15], 7) ^ rotr(w[j-15], 18) ^ (w[j-15] >> 3)) + w[j-16];
      end
      {h, g, f, e, d, c, b, a} = init;
      for (int r = 0; r < 64; r++) begin
         t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[r] + w[r];
         t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {h, g, f, e, d, c, b, a};
   endfunction

   // Whole-message reference: byte-level padding then chained compression
   function automatic logic [255:0] sha_model(input byte_q_t m);
      byte_q_t      bq;
      logic [63:0]  bl;
      logic [255:0] hv;
      logic [255:0] fv;
      logic [511:0] ch;
      logic [255:0] dg;
      bq = m;
      bl = 64'(m.size()) * 64'd8;
      bq.push_back(8'h80);
      while (bq.size() % 64 != 56) bq.push_back(8'h00);
      for (int i = 7; i >= 0; i--) bq.push_back(bl[8*i +: 8]);
      hv = IV_LANES;
      for (int c = 0; c < bq.size() / 64; c++) begin
         for (int j = 0; j < 16; j++) begin
            ch[32*j +: 32] = {bq[64*c+4*j], bq[64*c+4*j+1], bq[64*c+4*j+2], bq[64*c+4*j+3]};
         end
         fv = compress(hv, ch);
         for (int i = 0; i < 8; i++) hv[32*i +: 32] = hv[32*i +: 32] + fv[32*i +: 32];
      end
      for (int i = 0; i < 8; i++) dg[32*(7-i) +: 32] = hv[32*i +: 32];
      return dg;
   endfunction

   function automatic vec_t mk(input string txt, input int ln, input bit hd, input logic [255:0] dg,
                               input int st, input logic [31:0] w0, input logic [31:0] w15,
                               input bit mz, input int hold);
      vec_t v;
      v.txt = txt; v.len = ln; v.has_dig = hd; v.dig = dg; v.strobes = st;
      v.w0 = w0; v.w15 = w15; v.mid_zero = mz; v.hold = hold;
      return v;
   endfunction

   // Compression pipeline stand-in: 64-cycle latency, returns ori = captured init
   initial begin : stub
      logic [511:0] cap_chunk;
      logic [255:0] cap_init;
      forever begin
         @(negedge clk);
         if (c_validin) begin
            cap_chunk  = c_chunk;
            cap_init   = c_init;
            last_chunk = c_chunk;
            n_strobes++;
            @(negedge clk);
            chk("validin_pulse", c_validin, 1'b0);
            if (stub_en) begin
               repeat (62) @(negedge clk);
               if (busy) chk("chunk_stable", c_chunk, cap_chunk);
               c_final    = compress(cap_init, cap_chunk);
               c_ori      = cap_init;
               c_validout = 1'b1;
               @(negedge clk);
               c_validout = 1'b0;
            end
         end
      end
   end

   task automatic send_msg(input byte_q_t m, input bit with_last, input bit gaps);
      int          nw;
      int          tt;
      logic [31:0] wd;
      nw = (m.size() + 3) / 4;
      for (int w = 0; w < nw; w++) begin
         for (int k = 0; k < 4; k++) begin
            wd[31-8*k -: 8] = (4*w + k < m.size()) ? m[4*w+k] : 8'($urandom);
         end
         s_data  = wd;
         s_last  = with_last && (w == nw - 1);
         s_bytes = s_last ? 2'(m.size() % 4) : 2'($urandom);
         s_valid = 1'b1;
         tt = 0;
         while (!s_ready && tt < 400) begin
            @(negedge clk);
            tt++;
         end
         if (!s_ready) begin
            chk("send_timeout", s_ready, 1'b1);
            s_valid = 1'b0;
            s_last  = 1'b0;
            return;
         end
         @(negedge clk);
         s_valid = 1'b0;
         s_last  = 1'b0;
         if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   task automatic get_digest(input logic [255:0] exp, input int hold, input string tag);
      int tt;
      bit rdy_seen;
      bit stable;
      tt = 0; rdy_seen = 1'b0; stable = 1'b1;
      while (!d_valid && tt < 1000) begin
         if (s_ready) rdy_seen = 1'b1;
         @(negedge clk);
         tt++;
      end
      chk({tag, "_dvalid"}, d_valid, 1'b1);
      chk({tag, "_sready_low"}, rdy_seen, 1'b0);
      chk({tag, "_digest"}, d_digest, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!d_valid || d_digest !== exp || s_ready || !busy) stable = 1'b0;
      end
      if (hold > 0) chk({tag, "_hold_stable"}, stable, 1'b1);
      d_ready = 1'b1;
      @(negedge clk);
      d_ready = 1'b0;
      chk({tag, "_dvalid_clear"}, d_valid, 1'b0);
      chk({tag, "_idle"}, busy, 1'b0);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_chunk"}, c_chunk, '0);
      chk({tag, "_init"}, c_init, '0);
      chk({tag, "_digest"}, d_digest, '0);
      chk({tag, "_ctl"}, {s_ready, c_validin, d_valid, busy, err}, 5'b0);
   endtask

   function automatic byte_q_t str_msg(input string s);
      byte_q_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   initial begin : main
      vecs[0] = mk("abc", 0, 1'b1,
                   256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad,
                   1, 32'h61626380, 32'h00000018, 1'b1, 10);
      vecs[1] = mk("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 0, 1'b1,
                   256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1,
                   2, 32'h00000000, 32'h000001c0, 1'b1, 0);
      vecs[2] = mk("", 64, 1'b0, '0, 2, 32'h80000000, 32'h00000200, 1'b1, 2);
      vecs[3] = mk("", 55, 1'b0, '0, 1, 32'h61616161, 32'h000001b8, 1'b0, 0);
      vecs[4] = mk("", 60, 1'b0, '0, 2, 32'h00000000, 32'h000001e0, 1'b1, 0);
      vecs[5] = mk("", 57, 1'b0, '0, 2, 32'h00000000, 32'h000001c8, 1'b1, 0);
      vecs[6] = mk("", 52, 1'b0, '0, 1, 32'h61616161, 32'h000001a0, 1'b0, 0);
      vecs[7] = mk("a", 0, 1'b0, '0, 1, 32'h61800000, 32'h00000008, 1'b1, 0);

      repeat (3) @(negedge clk);
      check_zero_outputs("in_reset");
      reset = 1'b0;
      @(negedge clk);
      check_zero_outputs("after_reset");

      for (int v = 0; v < 8; v++) begin
         if (vecs[v].txt.len() > 0) begin
            msg = str_msg(vecs[v].txt);
         end else begin
            msg = {};
            for (int i = 0; i < vecs[v].len; i++) msg.push_back(8'h61);
         end
         exp_d = vecs[v].has_dig ? vecs[v].dig : sha_model(msg);
         s0 = n_strobes;
         send_msg(msg, 1'b1, 1'b0);
         get_digest(exp_d, vecs[v].hold, $sformatf("vec%0d", v));
         chk($sformatf("vec%0d_strobes", v), n_strobes - s0, vecs[v].strobes);
         chk($sformatf("vec%0d_w0", v), last_chunk[31:0], vecs[v].w0);
         chk($sformatf("vec%0d_w15", v), last_chunk[511:480], vecs[v].w15);
         if (vecs[v].mid_zero) chk($sformatf("vec%0d_mid_zero", v), last_chunk[479:32], '0);
      end

      for (int r = 0; r < 12; r++) begin
         len = $urandom_range(1, 140);
         msg = {};
         for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
         exp_d = sha_model(msg);
         s0 = n_strobes;
         send_msg(msg, 1'b1, 1'b1);
         get_digest(exp_d, $urandom_range(0, 3), $sformatf("rnd%0d_len%0d", r, len));
         chk($sformatf("rnd%0d_strobes", r), n_strobes - s0, (len + 72) / 64);
      end

      // Reset while the first chunk of an unfinished message is in the pipeline
      msg = {};
      for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
      send_msg(msg, 1'b0, 1'b0);
      t = 0;
      while (!c_validin && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("rst_mid_strobe", c_validin, 1'b1);
      repeat (20) @(negedge clk);
      chk("rst_mid_busy", busy, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check_zero_outputs("rst_mid");
      reset = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy || d_valid || c_validin) quiet = 1'b0;
      end
      chk("rst_late_result_ignored", quiet, 1'b1);
      send_msg(str_msg("abc"), 1'b1, 1'b0);
      get_digest(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 0, "rst_abc");

      // Pipeline never answers
      stub_en = 1'b0;
      send_msg(str_msg("abc"), 1'b1, 1'b0);
      t = 0;
      while (!c_validin && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("noresp_strobe", c_validin, 1'b1);
`ifdef SHA256_FEEDER_WDOG_EN
      repeat (128) @(negedge clk);
      chk("wdog_before", {err, busy}, 2'b01);
      @(negedge clk);
      chk("wdog_fired", {err, busy}, 2'b10);
      repeat (5) @(negedge clk);
      chk("wdog_sticky", err, 1'b1);
`else
      repeat (200) @(negedge clk);
      chk("nowdog_waiting", {err, busy}, 2'b01);
`endif
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_zero_outputs("final_reset");
      stub_en = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #900000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench time limit");
   end

endmodule
